fp16_to_fixed: RTL and testbench
================================

// Module: fp16_to_fixed
// PURPOSE
//  Converts an IEEE-754 half-precision value into signed two's-complement fixed point.
//  Uses a 2-stage valid/ready pipeline with full backpressure.
//  Sits downstream of the fp16 arithmetic blocks and decodes their packed results for
//  integer/DSP consumers, the reverse of the fp16 pack step.
// PARAMETERS
//  OUT_W   32  output width in bits, including sign; legal range 8..64
//  FRAC_W   8  fractional bits of output; legal range 0..OUT_W-2
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block accepts in_data this cycle; transfer when in_valid & in_ready
//  in_data    in   16     fp16 operand: [15] sign, [14:10] exponent (bias 15), [9:0] mantissa
//  out_valid  out  1      out_data/out_flags valid
//  out_ready  in   1      consumer accepts; transfer when out_valid & out_ready
//  out_data   out  OUT_W  fixed-point result, value*2^FRAC_W
//  out_flags  out  3      {nan, overflow, inexact}
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, out_flags=0. in_ready=0 while rst_n low.
//    Reset mid-operation drops all in-flight entries.
//  - Pipeline: S1 reg (classify, align) -> S2 reg (round, negate, saturate) = output reg.
//    Latency 2 clk from accepted input to out_valid. Capacity 2 entries, strictly in order.
//  - Advance rules: S2 loads when empty or out_ready. S1 loads when empty or S2 loads.
//    in_ready = !s1_valid | s2_load, a combinational path from out_ready.
//    Full-rate streaming with out_ready=1 has no bubbles. Nothing is lost or duplicated.
//  - Decode: M = {exp!=0, mant} (11b). E = exp for normal inputs, E = 1 for denormals.
//    |x|*2^FRAC_W = M << (E-25+FRAC_W) when that shift is >= 0.
//    Otherwise the right shift keeps guard and sticky bits.
//  - inexact = 1 when any discarded bit is nonzero. Saturated and NaN results do not set inexact.
//  - Saturation limits: MAX = 2^(OUT_W-1)-1, MIN = -2^(OUT_W-1).
//    Positive magnitude > MAX gives MAX and overflow=1.
//    Negative magnitude > 2^(OUT_W-1) gives MIN and overflow=1.
//    A negative magnitude of exactly 2^(OUT_W-1) is exact MIN with no overflow.
//    Overflow is checked after rounding.
//  - Special inputs:
//    +Inf -> MAX, overflow=1. -Inf -> MIN, overflow=1.
//    NaN (exp=31, mant!=0) -> 0, nan=1, other flags 0.
//    +0 and -0 -> 0, flags 0.
//  - Left-shift amounts >= OUT_W are overflow; no out-of-range shift is ever applied.
// CONFIGURATION
//  FP16_TO_FIXED_RNE_EN defined: round to nearest, ties to even, on the discarded bits.
//    Sign is applied after rounding, so rounding is symmetric about zero.
//  FP16_TO_FIXED_RNE_EN undefined: truncate toward zero; guard and sticky feed only inexact.
// STRUCTURE
//  - fp16_inc.vh gains FP16_EXP_BIAS (15), FP16_MANT_W (10), FP16_EXP_MAX (31) and
//    flag index constants FLAG_NAN=2, FLAG_OVF=1, FLAG_INX=0.
//  - Sub-module fp16_unpack: combinational decode of sign, E, M, is_zero, is_inf, is_nan.
//    It is reusable by the other fp16 blocks.
//  - The two pipeline stages and the handshake logic live in this module.
// TESTING (defaults OUT_W=32, FRAC_W=8 unless stated)
//  - 0x3C00 (1.0) -> 0x00000100, flags 000. 0xC100 (-2.5) -> 0xFFFFFD80, flags 000.
//    0x8000 -> 0, flags 000.
//  - Specials:
//    0x7E00 -> 0, flags 100.
//    0xFC00 -> 0x80000000, flags 010.
//    0x7C00 -> 0x7FFFFFFF, flags 010.
//  - Rounding:
//    0x1C00 (2^-8) -> 1, flags 000.
//    0x1A00 (0.75 LSB): RNE -> 1, trunc -> 0, inexact=1.
//    0x1800 (0.5 LSB): RNE -> 0 (tie to even), inexact=1.
//    0x0001 -> 0, inexact=1.
//  - OUT_W=16, FRAC_W=8:
//    0x5800 (128.0) -> 0x7FFF, flags 010.
//    0xD800 (-128.0) -> 0x8000, flags 000.
//    0x7BFF -> 0x7FFF, flags 010.
//  - Backpressure: stream 6 inputs back-to-back while out_ready=0 for 4 cycles.
//    in_ready drops after 2 accepts. All 6 outputs arrive in order, unchanged, none duplicated.
//  - Reset mid-stream with 2 entries in flight: out_valid=0 on the next cycle.
//    No stale output appears after rst_n rises. The first new input emerges 2 clk after acceptance.

Source files
------------

// File: rtl/fp16_to_fixed_pkg.sv
// Shared fp16 constants, decoded-field record and alignment helper used by
// the fp16 decode blocks.
package fp16_to_fixed_pkg;

  localparam int FP16_EXP_BIAS = 15;
  localparam int FP16_MANT_W   = 10;
  localparam int FP16_EXP_MAX  = 31;

  localparam int FLAG_NAN = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_INX = 0;

  typedef struct packed {
    logic        sign;
    logic [4:0]  exp_eff;
    logic [10:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp16_fields_t;

  // Shift that places the 11-bit significand at weight 2^-frac_w per LSB.
  // Negative results mean a right shift.
  function automatic logic [7:0] align_shift(input logic [4:0] e, input int frac_w);
    align_shift = 8'(int'(e) + frac_w - (FP16_EXP_BIAS + FP16_MANT_W));
  endfunction

endpackage

// File: rtl/fp16_unpack.sv
// Combinational fp16 field decoder: sign, effective exponent, significand
// with hidden bit, and zero/inf/nan classification.
module fp16_unpack
  import fp16_to_fixed_pkg::*;
(
  input  logic [15:0]  i_data,
  output fp16_fields_t o_fields
);

  logic [4:0] w_exp;
  logic [9:0] w_mant;
  logic       w_exp_nz;

  assign w_exp    = i_data[FP16_MANT_W +: 5];
  assign w_mant   = i_data[FP16_MANT_W-1:0];
  assign w_exp_nz = |w_exp;

  // Denormals share the exponent of the smallest normal but lack the hidden bit.
  always_comb begin
    o_fields         = '0;
    o_fields.sign    = i_data[15];
    o_fields.exp_eff = w_exp_nz ? w_exp : 5'd1;
    o_fields.mant    = {w_exp_nz, w_mant};
    o_fields.is_zero = !w_exp_nz && (w_mant == 10'd0);
    o_fields.is_inf  = (w_exp == 5'(FP16_EXP_MAX)) && (w_mant == 10'd0);
    o_fields.is_nan  = (w_exp == 5'(FP16_EXP_MAX)) && (w_mant != 10'd0);
  end

endmodule

// File: rtl/fp16_to_fixed.sv
// fp16 -> signed fixed-point converter, two-stage valid/ready pipeline.
// Stage 1 classifies and aligns, stage 2 rounds, negates and saturates.
// Define FP16_TO_FIXED_RNE_EN for round-to-nearest-even; otherwise the
// result is truncated toward zero.
module fp16_to_fixed
  import fp16_to_fixed_pkg::*;
#(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [2:0]       out_flags
);

  // Magnitude width: an 11-bit significand shifted left by up to OUT_W-1.
  localparam int                MW      = OUT_W + 12;
  localparam logic [MW-1:0]     LIM     = MW'(1) << (OUT_W - 1);
  localparam logic signed [7:0] OUT_W_S = 8'(OUT_W);
  localparam logic [OUT_W-1:0]  SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic             r_s1_nan;
  logic             r_s1_ovf;
  logic [MW-1:0]    r_s1_mag;
  logic             r_s1_guard;
  logic             r_s1_sticky;

  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_data;
  logic [2:0]       r_s2_flags;

  logic             w_s1_load;
  logic             w_s2_load;

  fp16_fields_t     w_f;
  logic signed [7:0] w_shift;
  logic             w_lovf;
  logic [6:0]       w_lsh_amt;
  logic [4:0]       w_rsh_amt;
  logic [MW-1:0]    w_lsh;
  logic [34:0]      w_rext;
  logic [MW-1:0]    w_mag;
  logic             w_guard;
  logic             w_sticky;

  logic             w_inc;
  logic [MW-1:0]    w_rnd;
  logic             w_inexact;
  logic [OUT_W-1:0] w_data;
  logic [2:0]       w_flags;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = rst_n && w_s1_load;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_flags = r_s2_flags;

  fp16_unpack u_unpack (
    .i_data   (in_data),
    .o_fields (w_f)
  );

  // Align the significand; oversize left shifts are flagged instead of applied.
  always_comb begin
    w_shift   = align_shift(w_f.exp_eff, FRAC_W);
    w_lovf    = !w_shift[7] && (w_shift >= OUT_W_S);
    w_lsh_amt = (w_shift[7] || w_lovf) ? 7'd0 : w_shift[6:0];
    w_rsh_amt = w_shift[7] ? 5'(-w_shift) : 5'd0;
    w_lsh     = {{(MW-11){1'b0}}, w_f.mant} << w_lsh_amt;
    w_rext    = {w_f.mant, 24'd0} >> w_rsh_amt;
    w_mag     = w_lsh;
    w_guard   = 1'b0;
    w_sticky  = 1'b0;
    if (w_shift[7]) begin
      w_mag    = MW'(w_rext[34:24]);
      w_guard  = w_rext[23];
      w_sticky = |w_rext[22:0];
    end
  end

  // Stage 1 register: captures the aligned magnitude and classification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_nan    <= 1'b0;
      r_s1_ovf    <= 1'b0;
      r_s1_mag    <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid  <= in_valid;
      r_s1_sign   <= w_f.sign;
      r_s1_nan    <= w_f.is_nan;
      r_s1_ovf    <= w_f.is_inf || (w_lovf && !w_f.is_nan);
      r_s1_mag    <= w_mag;
      r_s1_guard  <= w_guard;
      r_s1_sticky <= w_sticky;
    end
  end

  // Round the unsigned magnitude, then saturate and apply the sign.
  always_comb begin
`ifdef FP16_TO_FIXED_RNE_EN
    w_inc = r_s1_guard && (r_s1_sticky || r_s1_mag[0]);
`else
    w_inc = 1'b0;
`endif
    w_rnd     = r_s1_mag + MW'(w_inc);
    w_inexact = r_s1_guard || r_s1_sticky;
    w_data    = '0;
    w_flags   = '0;
    if (r_s1_nan) begin
      w_flags[FLAG_NAN] = 1'b1;
    end else if (r_s1_ovf || (!r_s1_sign && (w_rnd >= LIM)) ||
                 (r_s1_sign && (w_rnd > LIM))) begin
      w_data            = r_s1_sign ? SAT_MIN : SAT_MAX;
      w_flags[FLAG_OVF] = 1'b1;
    end else begin
      w_data            = r_s1_sign ? -w_rnd[OUT_W-1:0] : w_rnd[OUT_W-1:0];
      w_flags[FLAG_INX] = w_inexact;
    end
  end

  // Stage 2 register doubles as the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_flags <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      r_s2_data  <= w_data;
      r_s2_flags <= w_flags;
    end
  end

endmodule

// File: tb/tb_fp16_to_fixed.sv
// Testbench for fp16_to_fixed: two instances (OUT_W=32 and OUT_W=16, both
// FRAC_W=8) share the stimulus; results are compared against a table of
// known values and a real-arithmetic reference model.
module tb_fp16_to_fixed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic        outReady;
  logic [15:0] inData;

  logic        inReady32, outValid32, inReady16, outValid16;
  logic [31:0] outData32;
  logic [15:0] outData16;
  logic [2:0]  outFlags32, outFlags16;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] d32;
    logic [2:0]  f32;
    logic [15:0] d16;
    logic [2:0]  f16;
    int          stamp;
    bit          chkLat;
  } exp_t;

  typedef struct {
    logic [15:0] in;
    logic [31:0] d32;
    logic [2:0]  f32;
    logic [15:0] d16;
    logic [2:0]  f16;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[15];

  always #5 clk = ~clk;

  fp16_to_fixed #(.OUT_W(32), .FRAC_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady32),
    .in_data(inData), .out_valid(outValid32), .out_ready(outReady),
    .out_data(outData32), .out_flags(outFlags32)
  );

  fp16_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady16),
    .in_data(inData), .out_valid(outValid16), .out_ready(outReady),
    .out_data(outData16), .out_flags(outFlags16)
  );

  // Generic comparison with failure reporting
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact value from the fp16 fields in real arithmetic, then
  // rounding and saturation on the scaled magnitude.
  function automatic void refModel(input logic [15:0] x, input int ow, input int fw,
                                   output logic [63:0] d, output logic [2:0] f);
    int     e, mnt, p;
    real    a, fl, fr;
    longint m, lim;
    bit     neg;
    e   = int'(x[14:10]);
    mnt = int'(x[9:0]);
    neg = x[15];
    d   = '0;
    f   = '0;
    lim = longint'(1) << (ow - 1);
    if (e == 31) begin
      if (mnt != 0) f = 3'b100;
      else begin
        f = 3'b010;
        d = neg ? 64'(-lim) : 64'(lim - 1);
      end
    end else begin
      a = (e == 0) ? real'(mnt) : real'(1024 + mnt);
      p = ((e == 0) ? 1 : e) - 25 + fw;
      while (p > 0) begin a = a * 2.0; p--; end
      while (p < 0) begin a = a / 2.0; p++; end
      fl = $floor(a);
      fr = a - fl;
      m  = longint'(fl);
`ifdef FP16_TO_FIXED_RNE_EN
      if (fr > 0.5 || (fr == 0.5 && (m % 2) == 1)) m++;
`endif
      if (!neg && m >= lim) begin
        d = 64'(lim - 1);
        f = 3'b010;
      end else if (neg && m > lim) begin
        d = 64'(-lim);
        f = 3'b010;
      end else begin
        d = neg ? 64'(-m) : 64'(m);
        f = {2'b00, fr != 0.0};
      end
    end
  endfunction

  function automatic exp_t makeExp(input logic [15:0] x, input bit lat);
    exp_t        e;
    logic [63:0] d;
    logic [2:0]  f;
    refModel(x, 32, 8, d, f);
    e.d32 = d[31:0];
    e.f32 = f;
    refModel(x, 16, 8, d, f);
    e.d16    = d[15:0];
    e.f16    = f;
    e.stamp  = 0;
    e.chkLat = lat;
    return e;
  endfunction

  // One clock of stimulus; checks any output transfer against the scoreboard
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic ordy,
                               input exp_t e, output bit accepted);
    exp_t h;
    @(negedge clk);
    cycle++;
    inValid  = v;
    inData   = d;
    outReady = ordy;
    #1;
    if (outValid32 && outReady) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious output: got 0x%0h, required no output", outData32);
      end else begin
        h = sb.pop_front();
        checkOutput("valid16", 64'(outValid16), 64'd1);
        checkOutput("data32", 64'(outData32), 64'(h.d32));
        checkOutput("flags32", 64'(outFlags32), 64'(h.f32));
        checkOutput("data16", 64'(outData16), 64'(h.d16));
        checkOutput("flags16", 64'(outFlags16), 64'(h.f16));
        if (h.chkLat) checkOutput("latency", 64'(cycle - h.stamp), 64'd2);
      end
    end
    accepted = v && inReady32;
    if (accepted) begin
      h       = e;
      h.stamp = cycle;
      sb.push_back(h);
    end
  endtask

  // Send a single value with out_ready high and wait for it to drain
  task automatic sendOne(input logic [15:0] x, input exp_t e);
    bit acc = 1'b0;
    for (int n = 0; n < 10 && !acc; n++) applyStimulus(1'b1, x, 1'b1, e, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: got in_ready=0, required 1");
    end
    for (int n = 0; n < 10 && sb.size() != 0; n++) applyStimulus(1'b0, 16'h0, 1'b1, e, acc);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    exp_t        e;
    bit          acc;
    int          sent;
    logic [15:0] items[6];
    logic [15:0] pend;
    bit          havePend;

    vecs[0]  = '{16'h3C00, 32'h0000_0100, 3'b000, 16'h0100, 3'b000};
    vecs[1]  = '{16'hC100, 32'hFFFF_FD80, 3'b000, 16'hFD80, 3'b000};
    vecs[2]  = '{16'h8000, 32'h0000_0000, 3'b000, 16'h0000, 3'b000};
    vecs[3]  = '{16'h7E00, 32'h0000_0000, 3'b100, 16'h0000, 3'b100};
    vecs[4]  = '{16'hFC00, 32'h8000_0000, 3'b010, 16'h8000, 3'b010};
    vecs[5]  = '{16'h7C00, 32'h7FFF_FFFF, 3'b010, 16'h7FFF, 3'b010};
    vecs[6]  = '{16'h1C00, 32'h0000_0001, 3'b000, 16'h0001, 3'b000};
`ifdef FP16_TO_FIXED_RNE_EN
    vecs[7]  = '{16'h1A00, 32'h0000_0001, 3'b001, 16'h0001, 3'b001};
    vecs[8]  = '{16'h9A00, 32'hFFFF_FFFF, 3'b001, 16'hFFFF, 3'b001};
`else
    vecs[7]  = '{16'h1A00, 32'h0000_0000, 3'b001, 16'h0000, 3'b001};
    vecs[8]  = '{16'h9A00, 32'h0000_0000, 3'b001, 16'h0000, 3'b001};
`endif
    vecs[9]  = '{16'h1800, 32'h0000_0000, 3'b001, 16'h0000, 3'b001};
    vecs[10] = '{16'h0001, 32'h0000_0000, 3'b001, 16'h0000, 3'b001};
    vecs[11] = '{16'h5800, 32'h0000_8000, 3'b000, 16'h7FFF, 3'b010};
    vecs[12] = '{16'hD800, 32'hFFFF_8000, 3'b000, 16'h8000, 3'b000};
    vecs[13] = '{16'h7BFF, 32'h00FF_E000, 3'b000, 16'h7FFF, 3'b010};
    vecs[14] = '{16'h3E00, 32'h0000_0180, 3'b000, 16'h0180, 3'b000};

    rst_n    = 1'b0;
    inValid  = 1'b0;
    inData   = 16'h0;
    outReady = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset out_valid", 64'(outValid32), 64'd0);
    checkOutput("reset out_data", 64'(outData32), 64'd0);
    checkOutput("reset out_flags", 64'(outFlags32), 64'd0);
    checkOutput("reset in_ready", 64'(inReady32), 64'd0);
    checkOutput("reset out_valid16", 64'(outValid16), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 15; i++) begin
      e.d32    = vecs[i].d32;
      e.f32    = vecs[i].f32;
      e.d16    = vecs[i].d16;
      e.f16    = vecs[i].f16;
      e.stamp  = 0;
      e.chkLat = 1'b1;
      sendOne(vecs[i].in, e);
    end

    $display("[TB] backpressure sequence");
    for (int i = 0; i < 6; i++) items[i] = 16'($urandom_range(0, 65535));
    sent = 0;
    for (int c = 0; c < 40 && (sent < 6 || sb.size() != 0); c++) begin
      e = makeExp((sent < 6) ? items[sent] : 16'h0, 1'b0);
      applyStimulus(sent < 6, (sent < 6) ? items[sent] : 16'h0, c >= 4, e, acc);
      if (acc) sent++;
      if (c == 3) begin
        checkOutput("bp accepts", 64'(sent), 64'd2);
        checkOutput("bp in_ready", 64'(inReady32), 64'd0);
      end
    end
    checkOutput("bp sent", 64'(sent), 64'd6);
    checkOutput("bp drained", 64'(sb.size()), 64'd0);
    repeat (3) applyStimulus(1'b0, 16'h0, 1'b1, e, acc);

    $display("[TB] reset mid-stream");
    sent = 0;
    for (int c = 0; c < 4; c++) begin
      e = makeExp(16'h4000 + 16'(c), 1'b0);
      applyStimulus(1'b1, 16'h4000 + 16'(c), 1'b0, e, acc);
      if (acc) sent++;
    end
    checkOutput("inflight count", 64'(sent), 64'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("in_ready in reset", 64'(inReady32), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("out_valid after reset", 64'(outValid32), 64'd0);
    checkOutput("out_valid16 after reset", 64'(outValid16), 64'd0);
    sb.delete();
    rst_n = 1'b1;
    inValid = 1'b0;
    repeat (4) applyStimulus(1'b0, 16'h0, 1'b1, e, acc);
    sendOne(16'h4500, makeExp(16'h4500, 1'b1));

    $display("[TB] random streaming");
    havePend = 1'b0;
    pend     = 16'h0;
    for (int c = 0; c < 500; c++) begin
      if (!havePend) begin
        if ($urandom_range(0, 3) == 0)
          pend = {1'($urandom_range(0, 1)), 5'($urandom_range(18, 31)), 10'($urandom_range(0, 1023))};
        else
          pend = 16'($urandom_range(0, 65535));
        havePend = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(havePend, pend, $urandom_range(0, 3) != 0, makeExp(pend, 1'b0), acc);
      if (acc) havePend = 1'b0;
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) applyStimulus(1'b0, 16'h0, 1'b1, e, acc);
    checkOutput("random drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
